// File: rtl/clk_period_mon.sv
// clk_period_mon: measures period and high time of a slow clock (clk_in) in clk cycles,
// flags loss of signal after TIMEOUT cycles. Define CLK_PERIOD_MON_HIGH_TIME_EN to build high-time capture.
module clk_period_mon #(
    parameter int          CNT_W   = 16,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             timeout
);

    typedef enum logic [1:0] {IDLE, MEASURE, LOST} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state, state_nxt;
    logic             s1, s2, s3, rise_q;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             valid_nxt, to_set, to_clr;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            s3     <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            s1     <= clk_in;
            s2     <= s1;
            s3     <= s2;
            rise_q <= s2 & ~s3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rise_q) state_nxt = MEASURE;
            MEASURE: if (!rise_q && cnt == CNT_TO) state_nxt = LOST;
            LOST:    if (rise_q) state_nxt = MEASURE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        cnt_nxt   = cnt;
        valid_nxt = 1'b0;
        to_set    = 1'b0;
        to_clr    = 1'b0;
        case (state)
            IDLE: cnt_nxt = rise_q ? CNT_ONE : '0;
            MEASURE: begin
                if (rise_q) begin
                    cnt_nxt   = CNT_ONE;
                    valid_nxt = 1'b1;
                end else begin
                    cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
                    to_set  = (cnt == CNT_TO);
                end
            end
            LOST: begin
                if (rise_q) begin
                    cnt_nxt = CNT_ONE;
                    to_clr  = 1'b1;
                end
            end
            default: cnt_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            period  <= '0;
            valid   <= 1'b0;
            timeout <= 1'b0;
        end else begin
            cnt   <= cnt_nxt;
            valid <= valid_nxt;
            if (valid_nxt) period <= cnt;
            if (to_set)      timeout <= 1'b1;
            else if (to_clr) timeout <= 1'b0;
        end
    end

`ifdef CLK_PERIOD_MON_HIGH_TIME_EN
    logic             fall_q;
    logic [CNT_W-1:0] hi_cnt;

    // Falls outside MEASURE are ignored; the captured count is the cnt value at the fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fall_q    <= 1'b0;
            hi_cnt    <= '0;
            high_time <= '0;
        end else begin
            fall_q <= ~s2 & s3;
            if (state == MEASURE && fall_q) hi_cnt <= cnt;
            if (valid_nxt) high_time <= hi_cnt;
        end
    end
`else
    assign high_time = '0;
`endif

endmodule

// File: tb/tb_clk_period_mon.sv
// Scoreboard bench for clk_period_mon: two instances (16-bit/TIMEOUT=100 and 4-bit/TIMEOUT=15)
// share one clk_in; a waveform-level model predicts valid/timeout events and a monitor checks them.
module tb_clk_period_mon;

    localparam int TO0 = 100;
    localparam int TO1 = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        clk_in = 1'b0;
    logic [15:0] period0, high0;
    logic        valid0, tmo0;
    logic [3:0]  period1, high1;
    logic        valid1, tmo1;

    clk_period_mon #(.CNT_W(16), .TIMEOUT(TO0)) dut0 (
        .clk(clk), .rst_n(rst_n), .clk_in(clk_in),
        .period(period0), .high_time(high0), .valid(valid0), .timeout(tmo0)
    );

    clk_period_mon #(.CNT_W(4), .TIMEOUT(TO1)) dut1 (
        .clk(clk), .rst_n(rst_n), .clk_in(clk_in),
        .period(period1), .high_time(high1), .valid(valid1), .timeout(tmo1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef enum int {EV_VALID, EV_TO_SET, EV_TO_CLR} ev_kind_e;
    typedef struct {
        ev_kind_e kind;
        int       cyc;
        int       per;
        int       hi;
    } ev_t;
    typedef enum int {M_IDLE, M_RUN, M_LOST} mstate_e;

    ev_t     q0[$];
    ev_t     q1[$];
    mstate_e mst[2];
    int      last_r[2];
    int      last_hi[2];
    logic    prev_to[2];

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, exp);
        end
    endtask

    function automatic int tmo_of(int d);
        return (d == 0) ? TO0 : TO1;
    endfunction

    function automatic int hi_exp(int h);
`ifdef CLK_PERIOD_MON_HIGH_TIME_EN
        return h;
`else
        return 0;
`endif
    endfunction

    function automatic void push(int d, ev_t e);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endfunction

    // A rise of clk_in first sampled at edge r, starting a waveform period of p cycles with hi high.
    // Results show up three edges later; a period longer than TIMEOUT means loss of signal.
    task automatic model_rise(int r, int hi, int p);
        for (int d = 0; d < 2; d++) begin
            case (mst[d])
                M_RUN:  push(d, '{kind: EV_VALID, cyc: r + 3, per: r - last_r[d], hi: hi_exp(last_hi[d])});
                M_LOST: push(d, '{kind: EV_TO_CLR, cyc: r + 3, per: 0, hi: 0});
                default: ;
            endcase
            mst[d]     = M_RUN;
            last_r[d]  = r;
            last_hi[d] = hi;
            if (p > tmo_of(d)) begin
                push(d, '{kind: EV_TO_SET, cyc: r + 3 + tmo_of(d), per: 0, hi: 0});
                mst[d] = M_LOST;
            end
        end
    endtask

    task automatic expect_ev(int d, ev_kind_e kind, logic [31:0] per, logic [31:0] hi);
        ev_t e;
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            vectors++;
            miscompares++;
            $display("FAIL dut%0d_unexpected at cycle %0d: got event %s, expected no event", d, cyc, kind.name());
            return;
        end
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("dut%0d_event_kind", d), kind, e.kind);
        check($sformatf("dut%0d_event_cycle", d), cyc, e.cyc);
        if (kind == EV_VALID && e.kind == EV_VALID) begin
            check($sformatf("dut%0d_period", d), per, e.per);
            check($sformatf("dut%0d_high_time", d), hi, e.hi);
        end
    endtask

    task automatic mon(int d, logic v, logic to, logic [31:0] per, logic [31:0] hi);
        if (!rst_n) begin
            prev_to[d] = 1'b0;
            return;
        end
        if (v !== 1'b0) expect_ev(d, EV_VALID, per, hi);
        if (to !== prev_to[d]) begin
            expect_ev(d, (to === 1'b1) ? EV_TO_SET : EV_TO_CLR, 0, 0);
            prev_to[d] = to;
        end
    endtask

    always @(negedge clk) mon(0, valid0, tmo0, 32'(period0), 32'(high0));
    always @(negedge clk) mon(1, valid1, tmo1, 32'(period1), 32'(high1));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic seg(int hi, int lo);
        model_rise(cyc + 1, hi, hi + lo);
        clk_in = 1'b1;
        repeat (hi) step();
        clk_in = 1'b0;
        repeat (lo) step();
    endtask

    task automatic check_reset(string tag);
        check({tag, "_period0"}, 32'(period0), 0);
        check({tag, "_high0"},   32'(high0),   0);
        check({tag, "_valid0"},  32'(valid0),  0);
        check({tag, "_tmo0"},    32'(tmo0),    0);
        check({tag, "_period1"}, 32'(period1), 0);
        check({tag, "_high1"},   32'(high1),   0);
        check({tag, "_valid1"},  32'(valid1),  0);
        check({tag, "_tmo1"},    32'(tmo1),    0);
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset("midreset");
        q0.delete();
        q1.delete();
        mst = '{M_IDLE, M_IDLE};
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int hi, lo;
        mst     = '{M_IDLE, M_IDLE};
        prev_to = '{1'b0, 1'b0};
        #1 rst_n = 1'b0;
        #1 check_reset("reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) step();

        repeat (6) seg(4, 4);      // 50% duty, period 8
        repeat (4) seg(3, 7);      // period 10, high 3
        repeat (4) seg(5, 7);      // period 12 on both widths
        repeat (2) seg(8, 12);     // period 20: narrow instance times out
        repeat (3) seg(6, 6);
        seg(2, 98);                // rise lands exactly at cnt == TIMEOUT
        seg(5, 115);               // loss of signal on the wide instance
        repeat (2) seg(5, 5);

        model_rise(cyc + 1, 4, 12);
        clk_in = 1'b1;
        repeat (4) step();
        clk_in = 1'b0;
        repeat (3) step();
        reset_pulse();
        repeat (3) step();
        repeat (3) seg(4, 4);

        repeat (30) begin
            hi = $urandom_range(1, 10);
            lo = ($urandom_range(0, 5) == 0) ? $urandom_range(88, 104) : $urandom_range(1, 12);
            seg(hi, lo);
        end
        seg(4, 4);
        repeat (6) step();

        check("dut0_pending_events", q0.size(), 0);
        check("dut1_pending_events", q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
